var_sig_delay: RTL and testbench
================================

VAR_SIG_DELAY -- requirements
Module: var_sig_delay

Interface
REQ-001 SHALL have parameter BUS_BITS, default 1, width of delayed bus (>=1).
REQ-002 SHALL have parameter MAX_DELAY, default 16, largest supported delay in enabled cycles (>=1).
REQ-003 SHALL have derived constant DLY_BITS = clog2(MAX_DELAY+1), not overridable.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_en  input  1  clock enable; state advances only when high.
REQ-007 SHALL have port i_delay  input  DLY_BITS  requested delay in enabled cycles.
REQ-008 SHALL have port i_bus  input  BUS_BITS  data to delay.
REQ-009 SHALL have port o_bus  output  BUS_BITS  delayed data, zero while o_valid low.
REQ-010 SHALL have port o_valid  output  1  high when o_bus carries real delayed samples.
REQ-011 SHALL have port o_delay  output  DLY_BITS  delay currently applied (d_cur).

Function
REQ-012 SHALL clamp i_delay above MAX_DELAY to MAX_DELAY before any use.
REQ-013 SHALL hold storage of MAX_DELAY x BUS_BITS as a circular buffer, write pointer wr wrapping MAX_DELAY-1 -> 0.
REQ-014 On enabled cycle (i_en=1, rst=0): write i_bus at wr, advance wr, update fill counter.
REQ-015 On i_en=0: no write, wr/fill/d_cur hold, o_bus and o_valid hold their values.
REQ-016 For d_cur>=1, o_bus SHALL read combinationally at (wr - d_cur) mod MAX_DELAY, giving the sample written d_cur enabled cycles earlier.
REQ-017 For d_cur=0, o_bus SHALL equal i_bus combinationally and o_valid SHALL be 1.
REQ-018 Fill counter SHALL count enabled cycles since last reset/flush, saturating at MAX_DELAY.
REQ-019 o_valid SHALL be (fill >= d_cur); o_bus SHALL be forced to 0 when o_valid=0.
REQ-020 Delay change: on enabled cycle with clamp(i_delay) != d_cur, d_cur <= new value, fill <= 1 (current sample counts), write proceeds normally, wr not reset.
REQ-021 Delay changes on cycles with i_en=0 SHALL be ignored until the next enabled cycle.
REQ-022 Changing from D to any value SHALL drop o_valid the following cycle unless new value is 0 or 1.
REQ-023 d_cur = MAX_DELAY SHALL read the location about to be overwritten (read-before-write), giving exact MAX_DELAY latency.

Reset
REQ-024 rst SHALL set wr=0, fill=0, d_cur=clamp(i_delay) on the next rising edge.
REQ-025 After reset: o_valid=0 and o_bus=0 when d_cur>=1; o_valid=1, o_bus=i_bus when d_cur=0.
REQ-026 rst SHALL take priority over i_en; no write occurs on a reset cycle.
REQ-027 Storage contents SHALL NOT be reset; stale data masked by o_valid.
REQ-028 Reset mid-operation SHALL discard all in-flight samples.

Structure
REQ-029 Package sig_delay_pkg SHALL hold the DLY_BITS clog2 computation and the delay-clamp function.
REQ-030 Storage SHALL be sub-module sig_delay_ram: MAX_DELAY x BUS_BITS, sync write, async read, no reset.
REQ-031 Pointer, fill counter and d_cur logic SHALL stay in var_sig_delay.

Verification
REQ-032 BUS_BITS=8, MAX_DELAY=16, i_delay=4, i_en=1, i_bus=1,2,3,... after reset -> o_valid rises cycle 4, o_bus=1,2,3,... from then; zeros before.
REQ-033 Same setup, i_en toggled 1,0,1,0 -> o_bus emerges after 4 enabled cycles (8 clocks), values unchanged while i_en=0.
REQ-034 Running at delay 4, switch i_delay to 9 -> o_valid low next cycle, high 8 enabled cycles later, o_bus = sample written on change cycle.
REQ-035 i_delay=0 -> o_bus equals i_bus same cycle, o_valid=1; i_delay=31 -> o_delay=16, latency 16, wr wraps cleanly over 100 samples.
REQ-036 rst asserted with i_en=1 mid-stream at delay 5 -> next cycle o_valid=0, o_bus=0; first post-reset sample appears 5 enabled cycles later.

Source files
------------

// File: rtl/sig_delay_pkg.sv
// Shared helpers for the variable signal delay line: width computation and
// delay clamping used by both the top level and the bench-facing port widths.
package sig_delay_pkg;

    // Ceiling log2 usable in constant expressions.
    function automatic int sd_clog2(input int value);
        int res;
        int span;
        res  = 32'sd0;
        span = 32'sd1;
        while (span < value) begin
            span = span * 32'sd2;
            res  = res + 32'sd1;
        end
        return res;
    endfunction

    // A one-deep buffer still needs one address bit.
    function automatic int sd_addr_bits(input int depth);
        return (depth > 32'sd1) ? sd_clog2(depth) : 32'sd1;
    endfunction

    function automatic int unsigned sd_clamp_delay(input int unsigned req,
                                                   input int unsigned max_delay);
        return (req > max_delay) ? max_delay : req;
    endfunction

endpackage

// File: rtl/sig_delay_ram.sv
// Delay-line storage: synchronous write, asynchronous read, no reset.
// Contents are deliberately left uninitialised; the top level masks stale data.
module sig_delay_ram
    import sig_delay_pkg::*;
#(
    parameter int BUS_BITS  = 1,
    parameter int DEPTH     = 16,
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [BUS_BITS-1:0]  wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [BUS_BITS-1:0]  rdata
);

    logic [BUS_BITS-1:0] mem_r [DEPTH];

    // Sample capture into the circular buffer.
    always_ff @(posedge clk) begin
        if (we && (32'(waddr) < unsigned'(DEPTH))) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Combinational read; out-of-range addresses return zero.
    always_comb begin
        rdata = {BUS_BITS{1'b0}};
        if (32'(raddr) < unsigned'(DEPTH)) begin
            rdata = mem_r[raddr];
        end else begin
            rdata = {BUS_BITS{1'b0}};
        end
    end

endmodule

// File: rtl/var_sig_delay.sv
// Variable-latency delay line: delays i_bus by a run-time selectable number of
// enabled cycles, flagging o_valid once the buffer holds enough fresh samples.
module var_sig_delay
    import sig_delay_pkg::*;
#(
    parameter int  BUS_BITS  = 1,
    parameter int  MAX_DELAY = 16,
    localparam int DLY_BITS  = sd_clog2(MAX_DELAY + 32'sd1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_en,
    input  logic [DLY_BITS-1:0] i_delay,
    input  logic [BUS_BITS-1:0] i_bus,
    output logic [BUS_BITS-1:0] o_bus,
    output logic                o_valid,
    output logic [DLY_BITS-1:0] o_delay
);

    localparam int                   ADDR_BITS = sd_addr_bits(MAX_DELAY);
    localparam int                   EXT_BITS  = DLY_BITS + 32'sd1;
    localparam logic [DLY_BITS-1:0]  MAX_D     = DLY_BITS'(MAX_DELAY);
    localparam logic [EXT_BITS-1:0]  MAX_EXT   = EXT_BITS'(MAX_DELAY);
    localparam logic [ADDR_BITS-1:0] LAST_WR   = ADDR_BITS'(MAX_DELAY - 32'sd1);

    logic [ADDR_BITS-1:0] wr_r;
    logic [ADDR_BITS-1:0] wr_next_s;
    logic [DLY_BITS-1:0]  fill_r;
    logic [DLY_BITS-1:0]  fill_next_s;
    logic [DLY_BITS-1:0]  d_cur_r;
    logic [DLY_BITS-1:0]  d_req_s;
    logic                 d_change_s;
    logic [EXT_BITS-1:0]  wr_ext_s;
    logic [EXT_BITS-1:0]  d_ext_s;
    logic [EXT_BITS-1:0]  rd_ext_s;
    logic [ADDR_BITS-1:0] rd_addr_s;
    logic [BUS_BITS-1:0]  rd_data_s;
    logic                 we_s;
    logic                 valid_s;

    assign d_req_s    = DLY_BITS'(sd_clamp_delay(32'(i_delay), unsigned'(MAX_DELAY)));
    assign d_change_s = (d_req_s != d_cur_r);
    assign we_s       = i_en & ~rst;

    // Write pointer wrap and fill update; a delay change restarts the fill at
    // one because the sample written on that cycle already counts.
    always_comb begin
        wr_next_s   = wr_r;
        fill_next_s = fill_r;
        if (wr_r == LAST_WR) begin
            wr_next_s = {ADDR_BITS{1'b0}};
        end else begin
            wr_next_s = wr_r + ADDR_BITS'(1'b1);
        end
        if (d_change_s) begin
            fill_next_s = DLY_BITS'(1'b1);
        end else if (fill_r < MAX_D) begin
            fill_next_s = fill_r + DLY_BITS'(1'b1);
        end else begin
            fill_next_s = fill_r;
        end
    end

    // Pointer, fill counter and applied delay; reset wins over the enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_r    <= {ADDR_BITS{1'b0}};
            fill_r  <= {DLY_BITS{1'b0}};
            d_cur_r <= d_req_s;
        end else if (i_en) begin
            wr_r    <= wr_next_s;
            fill_r  <= fill_next_s;
            d_cur_r <= d_req_s;
        end else begin
            wr_r    <= wr_r;
            fill_r  <= fill_r;
            d_cur_r <= d_cur_r;
        end
    end

    // Read index (wr - d_cur) mod MAX_DELAY; at d_cur == MAX_DELAY this is the
    // slot about to be overwritten, which the async read returns before the write.
    always_comb begin
        wr_ext_s = EXT_BITS'(wr_r);
        d_ext_s  = EXT_BITS'(d_cur_r);
        if (wr_ext_s >= d_ext_s) begin
            rd_ext_s = wr_ext_s - d_ext_s;
        end else begin
            rd_ext_s = wr_ext_s + MAX_EXT - d_ext_s;
        end
        rd_addr_s = ADDR_BITS'(rd_ext_s);
    end

    sig_delay_ram #(
        .BUS_BITS  (BUS_BITS),
        .DEPTH     (MAX_DELAY),
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk   (clk),
        .we    (we_s),
        .waddr (wr_r),
        .wdata (i_bus),
        .raddr (rd_addr_s),
        .rdata (rd_data_s)
    );

    // Output select: zero delay bypasses storage, otherwise stale data is masked.
    always_comb begin
        valid_s = (fill_r >= d_cur_r);
        o_valid = valid_s;
        o_bus   = {BUS_BITS{1'b0}};
        if (d_cur_r == {DLY_BITS{1'b0}}) begin
            o_bus = i_bus;
        end else if (valid_s) begin
            o_bus = rd_data_s;
        end else begin
            o_bus = {BUS_BITS{1'b0}};
        end
    end

    assign o_delay = d_cur_r;

endmodule

// File: tb/tb_var_sig_delay.sv
// Scoreboard bench for var_sig_delay: stimulus pushes expected outputs per
// cycle, a monitor pops and compares them half a clock later.
module tb_var_sig_delay;

    localparam int BB = 8;
    localparam int MD = 16;
    localparam int DB = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_en;
    logic [DB-1:0] i_delay;
    logic [BB-1:0] i_bus;
    logic [BB-1:0] o_bus;
    logic          o_valid;
    logic [DB-1:0] o_delay;

    always #5 clk = ~clk;

    var_sig_delay #(
        .BUS_BITS  (BB),
        .MAX_DELAY (MD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_en    (i_en),
        .i_delay (i_delay),
        .i_bus   (i_bus),
        .o_bus   (o_bus),
        .o_valid (o_valid),
        .o_delay (o_delay)
    );

    typedef struct packed {
        logic          valid;
        logic [BB-1:0] bus;
        logic [DB-1:0] dly;
    } exp_t;

    exp_t          exp_q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    bit            done  = 1'b0;

    // Reference: full history of written samples, enabled cycles since the
    // last reset/delay change, and the applied delay.
    logic [BB-1:0] hist_m[$];
    int            seg_m  = 0;
    int            dcur_m = 0;

    function automatic int clampd(input int d);
        return (d > MD) ? MD : d;
    endfunction

    task automatic step(input logic r, input logic en, input int dly,
                        input logic [BB-1:0] bus, input bit chk);
        exp_t e;
        rst     = r;
        i_en    = en;
        i_delay = DB'(dly);
        i_bus   = bus;
        if (chk) begin
            e.dly = DB'(dcur_m);
            if (dcur_m == 0) begin
                e.valid = 1'b1;
                e.bus   = bus;
            end else if (seg_m >= dcur_m) begin
                e.valid = 1'b1;
                e.bus   = hist_m[hist_m.size() - dcur_m];
            end else begin
                e.valid = 1'b0;
                e.bus   = 8'h00;
            end
            exp_q.push_back(e);
        end
        @(posedge clk);
        if (r) begin
            hist_m.delete();
            seg_m  = 0;
            dcur_m = clampd(dly);
        end else if (en) begin
            hist_m.push_back(bus);
            if (clampd(dly) != dcur_m) begin
                dcur_m = clampd(dly);
                seg_m  = 1;
            end else begin
                seg_m = seg_m + 1;
            end
        end
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        int   cyc;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp = n_cmp + 1;
                if (o_valid !== e.valid) begin
                    n_err = n_err + 1;
                    $display("FAIL o_valid cyc %0d: got %b want %b", cyc, o_valid, e.valid);
                end
                n_cmp = n_cmp + 1;
                if (o_bus !== e.bus) begin
                    n_err = n_err + 1;
                    $display("FAIL o_bus cyc %0d: got %02h want %02h", cyc, o_bus, e.bus);
                end
                n_cmp = n_cmp + 1;
                if (o_delay !== e.dly) begin
                    n_err = n_err + 1;
                    $display("FAIL o_delay cyc %0d: got %0d want %0d", cyc, o_delay, e.dly);
                end
            end else if (done) begin
                break;
            end
            if (cyc > 5000) begin
                n_err = n_err + 1;
                $display("FAIL watchdog: got %0d cycles want at most 5000", cyc);
                break;
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : stimulus
        rst     = 1'b1;
        i_en    = 1'b0;
        i_delay = 5'd0;
        i_bus   = 8'h00;
        step(1'b1, 1'b0, 4, 8'h00, 1'b0);
        step(1'b1, 1'b1, 4, 8'h00, 1'b0);

        // Delay 4, continuous enable, ramp data.
        for (int i = 1; i <= 12; i++) step(1'b0, 1'b1, 4, 8'(i), 1'b1);

        // Reset while enabled, then alternate enable; disabled cycles carry junk.
        step(1'b1, 1'b1, 4, 8'hAA, 1'b1);
        for (int i = 0; i < 20; i++)
            step(1'b0, (i % 2 == 0), 4, (i % 2 == 0) ? 8'(8'h40 + i) : 8'hEE, 1'b1);

        // Delay change 4 -> 9, first requested on a disabled cycle.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 4, 8'(8'h60 + i), 1'b1);
        step(1'b0, 1'b0, 9, 8'h77, 1'b1);
        for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 9, 8'(8'h80 + i), 1'b1);

        // Zero delay bypass, including a disabled cycle, then 0 -> 1.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 0, 8'(8'hC0 + 7 * i), 1'b1);
        step(1'b0, 1'b0, 0, 8'h5A, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1, 8'(8'hD0 + i), 1'b1);

        // Over-range request clamps to MAX_DELAY; long run exercises wrap.
        step(1'b1, 1'b1, 31, 8'h00, 1'b1);
        for (int i = 0; i < 110; i++) step(1'b0, 1'b1, 31, 8'(i + 1), 1'b1);

        // Delay 5 stream, reset mid-stream with enable high.
        step(1'b1, 1'b0, 5, 8'h00, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 5, 8'(8'h10 + i), 1'b1);
        step(1'b1, 1'b1, 5, 8'hFF, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 5, 8'(8'h30 + i), 1'b1);

        done = 1'b1;
    end

endmodule
